// File: rtl/piso_pkg.sv
// Shared definitions for the piso_shift_tx transmitter: FSM encoding and size helpers.
// Defining PISO_TX_PARITY_EN appends one odd-parity bit to every transmitted word.
package piso_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_e;

  function automatic int clog2_f(input int n);
    int r;
    r = 1;
    while ((1 << r) < n) r++;
    return r;
  endfunction

  // Number of bit times per word, including the parity bit when it is built in.
  function automatic int nbits_f(input int width);
`ifdef PISO_TX_PARITY_EN
    return width + 1;
`else
    return width;
`endif
  endfunction

endpackage

// File: rtl/piso_shift_tx_if.sv
// Load/data/inhibit request side and serial/status side of the piso_shift_tx transmitter.
interface piso_shift_tx_if #(
  parameter int WIDTH = 8
);
  logic             LOAD;
  logic [WIDTH-1:0] D;
  logic             CLK_INH;
  logic             Q;
  logic             BUSY;
  logic             DONE;
  logic             OVR;

  modport master (
    output LOAD, D, CLK_INH,
    input  Q, BUSY, DONE, OVR
  );

  modport slave (
    input  LOAD, D, CLK_INH,
    output Q, BUSY, DONE, OVR
  );
endinterface

// File: rtl/piso_bit_counter.sv
// Loadable down-counter tracking remaining bit times; freezes when en is low.
module piso_bit_counter #(
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic             en,
  input  logic             ld,
  input  logic [CNT_W-1:0] ld_val,
  input  logic             dec,
  output logic             zero_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (en) begin
      if (ld) begin
        cnt_d = ld_val;
      end else if (dec && (cnt_q != '0)) begin
        cnt_d = cnt_q - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/piso_shift_tx.sv
// Parallel-in/serial-out transmitter with BUSY/DONE handshake, overrun flag and clock inhibit.
// Optional build macro PISO_TX_PARITY_EN sends an odd-parity bit after the data bits.
module piso_shift_tx
  import piso_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input logic            CLK,
  input logic            CLR_N,
  piso_shift_tx_if.slave bus
);

  localparam int               NBITS   = nbits_f(WIDTH);
  localparam int               CNT_W   = clog2_f(NBITS);
  localparam logic [CNT_W-1:0] CNT_TOP = CNT_W'(NBITS - 1);

  state_e           state_q, state_d;
  logic [NBITS-1:0] sr_q, sr_d;
  logic             q_q, q_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             ovr_q, ovr_d;

  logic [NBITS-1:0] word_seq;
  logic             accept;
  logic             cnt_zero;

  // word_seq[0] is the bit on the wire first; the rest follow in index order.
  always_comb begin
    word_seq = '0;
    for (int i = 0; i < WIDTH; i++) begin
      word_seq[i] = MSB_FIRST ? bus.D[WIDTH-1-i] : bus.D[i];
    end
`ifdef PISO_TX_PARITY_EN
    word_seq[WIDTH] = ~^bus.D;
`endif
  end

  assign accept = bus.LOAD && ((state_q == ST_IDLE) || cnt_zero);

  piso_bit_counter #(
    .CNT_W (CNT_W)
  ) u_cnt (
    .clk    (CLK),
    .clr_n  (CLR_N),
    .en     (~bus.CLK_INH),
    .ld     (accept),
    .ld_val (CNT_TOP),
    .dec    ((state_q == ST_SHIFT) && !cnt_zero),
    .zero_o (cnt_zero)
  );

  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    q_d     = q_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    ovr_d   = 1'b0;
    if (!bus.CLK_INH) begin
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            sr_d    = word_seq >> 1;
            q_d     = word_seq[0];
            busy_d  = 1'b1;
            state_d = ST_SHIFT;
          end else begin
            q_d    = 1'b0;
            busy_d = 1'b0;
          end
        end
        ST_SHIFT: begin
          if (!cnt_zero) begin
            sr_d  = sr_q >> 1;
            q_d   = sr_q[0];
            ovr_d = bus.LOAD;
          end else begin
            // Last bit time is over; a load here chains the next word with no gap.
            done_d = 1'b1;
            if (accept) begin
              sr_d    = word_seq >> 1;
              q_d     = word_seq[0];
              busy_d  = 1'b1;
              state_d = ST_SHIFT;
            end else begin
              sr_d    = '0;
              q_d     = 1'b0;
              busy_d  = 1'b0;
              state_d = ST_IDLE;
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge CLR_N) begin
    if (!CLR_N) begin
      state_q <= ST_IDLE;
      sr_q    <= '0;
      q_q     <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      q_q     <= q_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      ovr_q   <= ovr_d;
    end
  end

  assign bus.Q    = q_q;
  assign bus.BUSY = busy_q;
  assign bus.DONE = done_q;
  assign bus.OVR  = ovr_q;

endmodule

// File: tb/tb_piso_shift_tx.sv
// Scoreboard bench for piso_shift_tx: MSB-first and LSB-first instances on a shared clock/reset.
module tb_piso_shift_tx;

  localparam int WIDTH = 8;
`ifdef PISO_TX_PARITY_EN
  localparam int NB = WIDTH + 1;
`else
  localparam int NB = WIDTH;
`endif

  logic clk   = 1'b0;
  logic clr_n = 1'b0;
  always #5 clk = ~clk;

  piso_shift_tx_if #(.WIDTH(WIDTH)) if_m ();
  piso_shift_tx_if #(.WIDTH(WIDTH)) if_l ();

  piso_shift_tx #(.WIDTH(WIDTH), .MSB_FIRST(1'b1)) u_msb (.CLK(clk), .CLR_N(clr_n), .bus(if_m));
  piso_shift_tx #(.WIDTH(WIDTH), .MSB_FIRST(1'b0)) u_lsb (.CLK(clk), .CLR_N(clr_n), .bus(if_l));

  bit   sel = 1'b0;
  logic mq, mbusy, mdone, movr;
  assign mq    = sel ? if_l.Q    : if_m.Q;
  assign mbusy = sel ? if_l.BUSY : if_m.BUSY;
  assign mdone = sel ? if_l.DONE : if_m.DONE;
  assign movr  = sel ? if_l.OVR  : if_m.OVR;

  int   n_checks = 0;
  int   n_fail   = 0;
  logic exp_q[$];

  function automatic logic exp_bit(input logic [WIDTH-1:0] d, input int i, input bit msb);
    if (i >= WIDTH) return ~^d;
    return msb ? d[WIDTH-1-i] : d[i];
  endfunction

  task automatic drive(input logic load, input logic [WIDTH-1:0] d, input logic inh);
    if_m.LOAD    = sel ? 1'b0 : load;
    if_m.D       = d;
    if_m.CLK_INH = sel ? 1'b0 : inh;
    if_l.LOAD    = sel ? load : 1'b0;
    if_l.D       = d;
    if_l.CLK_INH = sel ? inh : 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_word(input logic [WIDTH-1:0] d);
    for (int i = 0; i < NB; i++) exp_q.push_back(exp_bit(d, i, !sel));
  endtask

  task automatic test_reset();
    #1;
    n_checks++; if (if_m.Q !== 1'b0 || if_m.BUSY !== 1'b0) begin n_fail++; $display("FAIL reset_msb_q_busy: got %b%b want 00", if_m.Q, if_m.BUSY); end
    n_checks++; if (if_m.DONE !== 1'b0 || if_m.OVR !== 1'b0) begin n_fail++; $display("FAIL reset_msb_done_ovr: got %b%b want 00", if_m.DONE, if_m.OVR); end
    n_checks++; if (if_l.Q !== 1'b0 || if_l.BUSY !== 1'b0 || if_l.DONE !== 1'b0 || if_l.OVR !== 1'b0) begin n_fail++; $display("FAIL reset_lsb: got %b%b%b%b want 0000", if_l.Q, if_l.BUSY, if_l.DONE, if_l.OVR); end
    step();
    #3 clr_n = 1'b1;
    step();
    n_checks++; if (mbusy !== 1'b0 || mq !== 1'b0) begin n_fail++; $display("FAIL idle_after_reset: busy=%b q=%b want 0 0", mbusy, mq); end
  endtask

  task automatic run_word(input logic [WIDTH-1:0] d, input string name);
    logic e;
    push_word(d);
    drive(1'b1, d, 1'b0);
    step();
    drive(1'b0, '0, 1'b0);
    for (int k = 0; k < NB; k++) begin
      e = exp_q.pop_front();
      n_checks++; if (mq !== e) begin n_fail++; $display("FAIL %s_q bit%0d: got %b want %b", name, k, mq, e); end
      n_checks++; if (mbusy !== 1'b1 || mdone !== 1'b0 || movr !== 1'b0) begin n_fail++; $display("FAIL %s_status bit%0d: busy/done/ovr=%b%b%b want 100", name, k, mbusy, mdone, movr); end
      step();
    end
    n_checks++; if (mdone !== 1'b1 || mbusy !== 1'b0 || mq !== 1'b0) begin n_fail++; $display("FAIL %s_end: done/busy/q=%b%b%b want 100", name, mdone, mbusy, mq); end
    step();
    n_checks++; if (mdone !== 1'b0) begin n_fail++; $display("FAIL %s_done_pulse: done=%b want 0", name, mdone); end
  endtask

  task automatic test_msb_first();
    sel = 1'b0;
    run_word(8'hA5, "msb_a5");
  endtask

  task automatic test_lsb_first();
    sel = 1'b1;
    run_word(8'hA5, "lsb_a5");
    run_word(8'h01, "lsb_01");
    sel = 1'b0;
    drive(1'b0, '0, 1'b0);
  endtask

  task automatic test_back_to_back();
    logic e;
    sel = 1'b0;
    push_word(8'hFF);
    push_word(8'h00);
    drive(1'b1, 8'hFF, 1'b0);
    step();
    for (int k = 0; k < 2 * NB; k++) begin
      e = exp_q.pop_front();
      n_checks++; if (mq !== e) begin n_fail++; $display("FAIL b2b_q bit%0d: got %b want %b", k, mq, e); end
      n_checks++; if (mbusy !== 1'b1) begin n_fail++; $display("FAIL b2b_busy bit%0d: got %b want 1", k, mbusy); end
      n_checks++; if (mdone !== (k == NB) || movr !== 1'b0) begin n_fail++; $display("FAIL b2b_done bit%0d: done/ovr=%b%b want %b0", k, mdone, movr, (k == NB)); end
      if (k == NB - 1) drive(1'b1, 8'h00, 1'b0);
      else             drive(1'b0, 8'h00, 1'b0);
      step();
    end
    n_checks++; if (mdone !== 1'b1 || mbusy !== 1'b0 || mq !== 1'b0) begin n_fail++; $display("FAIL b2b_end: done/busy/q=%b%b%b want 100", mdone, mbusy, mq); end
    step();
  endtask

  task automatic test_overrun_inhibit();
    logic e, ld, inh, ovr_exp, ovr_done;
    int   b, views, inh_cnt;
    sel = 1'b0;
    push_word(8'h3C);
    drive(1'b1, 8'h3C, 1'b0);
    step();
    b = 0; views = 0; inh_cnt = 0; ovr_exp = 1'b0; ovr_done = 1'b0;
    e = exp_q.pop_front();
    while (b < NB && views < NB + 10) begin
      n_checks++; if (mq !== e || mbusy !== 1'b1) begin n_fail++; $display("FAIL ovr_q view%0d: q/busy=%b%b want %b1", views, mq, mbusy, e); end
      n_checks++; if (mdone !== 1'b0 || movr !== ovr_exp) begin n_fail++; $display("FAIL ovr_flags view%0d: done/ovr=%b%b want 0%b", views, mdone, movr, ovr_exp); end
      ld  = (b == 3) && !ovr_done;
      inh = (b == 4) && (inh_cnt < 2);
      drive(ld, 8'hFF, inh);
      step();
      views++;
      if (inh) begin
        inh_cnt++;
        ovr_exp = 1'b0;
      end else begin
        b++;
        ovr_exp = ld;
        if (ld) ovr_done = 1'b1;
        if (b < NB) e = exp_q.pop_front();
      end
    end
    drive(1'b0, '0, 1'b0);
    n_checks++; if (mdone !== 1'b1 || mbusy !== 1'b0) begin n_fail++; $display("FAIL ovr_end: done/busy=%b%b want 10", mdone, mbusy); end
    n_checks++; if (views !== NB + 2) begin n_fail++; $display("FAIL inh_delay: done after %0d edges want %0d", views, NB + 2); end
    n_checks++; if (exp_q.size() !== 0) begin n_fail++; $display("FAIL ovr_scoreboard: %0d bits left want 0", exp_q.size()); end
    step();
    drive(1'b1, 8'hAA, 1'b1);
    step();
    n_checks++; if (mbusy !== 1'b0 || mq !== 1'b0 || mdone !== 1'b0) begin n_fail++; $display("FAIL inh_idle_load: busy/q/done=%b%b%b want 000", mbusy, mq, mdone); end
    drive(1'b0, '0, 1'b0);
    step();
  endtask

  task automatic test_async_reset();
    logic e;
    sel = 1'b0;
    push_word(8'hA5);
    drive(1'b1, 8'hA5, 1'b0);
    step();
    drive(1'b0, '0, 1'b0);
    for (int k = 0; k <= 5; k++) begin
      e = exp_q.pop_front();
      n_checks++; if (mq !== e) begin n_fail++; $display("FAIL rst_pre_q bit%0d: got %b want %b", k, mq, e); end
      if (k < 5) step();
    end
    #2 clr_n = 1'b0;
    #1;
    n_checks++; if (mq !== 1'b0 || mbusy !== 1'b0 || mdone !== 1'b0) begin n_fail++; $display("FAIL rst_async: q/busy/done=%b%b%b want 000", mq, mbusy, mdone); end
    exp_q.delete();
    for (int k = 0; k < 2; k++) begin
      step();
      n_checks++; if (mdone !== 1'b0 || mbusy !== 1'b0) begin n_fail++; $display("FAIL rst_hold%0d: done/busy=%b%b want 00", k, mdone, mbusy); end
    end
    #3 clr_n = 1'b1;
    run_word(8'h81, "rst_81");
  endtask

`ifdef PISO_TX_PARITY_EN
  task automatic test_parity();
    sel = 1'b0;
    run_word(8'hA5, "par_a5");
    run_word(8'h07, "par_07");
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    drive(1'b0, '0, 1'b0);
    test_reset();
    test_msb_first();
    test_lsb_first();
    test_back_to_back();
    test_overrun_inhibit();
    test_async_reset();
`ifdef PISO_TX_PARITY_EN
    test_parity();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
